// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file writeback arbiter with single-entry skid buffers and bounded starvation of wb1.
// Optional pending-write scoreboard (busy_out) is built only when RF_WB_SCOREBOARD_EN is defined.
module rf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        wb0_valid_in,
  output logic        wb0_ready_out,
  input  logic [4:0]  wb0_rd_in,
  input  logic [31:0] wb0_data_in,
  input  logic        wb1_valid_in,
  output logic        wb1_ready_out,
  input  logic [4:0]  wb1_rd_in,
  input  logic [31:0] wb1_data_in,
  input  logic        sb_set_valid_in,
  input  logic [4:0]  sb_set_rd_in,
  output logic [31:0] busy_out,
  output logic        rf_we_out,
  output logic [4:0]  rf_waddr_out,
  output logic [31:0] rf_wdata_out
);

  localparam int unsigned REG_AW = 5;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic              full0;
  logic [REG_AW-1:0] rd0;
  logic [XLEN-1:0]   data0;
  logic              full1;
  logic [REG_AW-1:0] rd1;
  logic [XLEN-1:0]   data1;
  logic [CNT_W-1:0]  starve_cnt;

  logic starve_hit;
  logic grant0;
  logic grant1;
  logic store0;
  logic store1;

  // Grants depend only on registered state so ready never combinationally follows valid.
  always_comb begin
    starve_hit = (starve_cnt == LIMIT);
    grant0     = full0 & (~full1 | ~starve_hit);
    grant1     = full1 & (~full0 | starve_hit);
  end

  assign wb0_ready_out = ~full0 | grant0;
  assign wb1_ready_out = ~full1 | grant1;

  // Requests targeting x0 complete the handshake but are discarded.
  assign store0 = wb0_valid_in & wb0_ready_out & (wb0_rd_in != '0);
  assign store1 = wb1_valid_in & wb1_ready_out & (wb1_rd_in != '0);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      full0 <= 1'b0;
      rd0   <= '0;
      data0 <= '0;
    end else if (store0) begin
      full0 <= 1'b1;
      rd0   <= wb0_rd_in;
      data0 <= wb0_data_in;
    end else if (grant0) begin
      full0 <= 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      full1 <= 1'b0;
      rd1   <= '0;
      data1 <= '0;
    end else if (store1) begin
      full1 <= 1'b1;
      rd1   <= wb1_rd_in;
      data1 <= wb1_data_in;
    end else if (grant1) begin
      full1 <= 1'b0;
    end
  end

  // Counts wb0 wins while wb1 waits; reaching LIMIT hands the next slot to wb1.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      starve_cnt <= '0;
    end else if (grant1 || !full1) begin
      starve_cnt <= '0;
    end else if (grant0 && !starve_hit) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rf_we_out    <= 1'b0;
      rf_waddr_out <= '0;
      rf_wdata_out <= '0;
    end else if (grant1) begin
      rf_we_out    <= 1'b1;
      rf_waddr_out <= rd1;
      rf_wdata_out <= data1;
    end else if (grant0) begin
      rf_we_out    <= 1'b1;
      rf_waddr_out <= rd0;
      rf_wdata_out <= data0;
    end else begin
      rf_we_out    <= 1'b0;
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;

  // Set beats clear on the same register; x0 is never marked pending.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (sb_set_valid_in && (sb_set_rd_in != '0)) begin
      set_mask[sb_set_rd_in] = 1'b1;
    end
    if (grant1) begin
      clr_mask[rd1] = 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      busy_q <= '0;
    end else begin
      busy_q <= ((busy_q & ~clr_mask) | set_mask) & ~NREGS'(1);
    end
  end

  assign busy_out = busy_q;
`else
  logic unused_sb;
  assign unused_sb = ^{sb_set_valid_in, sb_set_rd_in};
  assign busy_out  = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_rf_wb_arbiter;

  localparam int LIMIT = 4;
`ifdef RF_WB_SCOREBOARD_EN
  localparam bit SB_ON = 1'b1;
`else
  localparam bit SB_ON = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        areset;
  logic        wb0_valid_in, wb1_valid_in, sb_set_valid_in;
  logic        wb0_ready_out, wb1_ready_out;
  logic [4:0]  wb0_rd_in, wb1_rd_in, sb_set_rd_in;
  logic [31:0] wb0_data_in, wb1_data_in;
  logic [31:0] busy_out;
  logic        rf_we_out;
  logic [4:0]  rf_waddr_out;
  logic [31:0] rf_wdata_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: one pending entry per requester plus observable outputs.
  bit          m_full[2];
  logic [4:0]  m_rd[2];
  logic [31:0] m_data[2];
  int          m_starve;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_busy;

  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .aclk(aclk), .areset(areset),
    .wb0_valid_in(wb0_valid_in), .wb0_ready_out(wb0_ready_out),
    .wb0_rd_in(wb0_rd_in), .wb0_data_in(wb0_data_in),
    .wb1_valid_in(wb1_valid_in), .wb1_ready_out(wb1_ready_out),
    .wb1_rd_in(wb1_rd_in), .wb1_data_in(wb1_data_in),
    .sb_set_valid_in(sb_set_valid_in), .sb_set_rd_in(sb_set_rd_in),
    .busy_out(busy_out),
    .rf_we_out(rf_we_out), .rf_waddr_out(rf_waddr_out), .rf_wdata_out(rf_wdata_out)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full[0] = 0; m_full[1] = 0;
    m_rd[0] = '0; m_rd[1] = '0;
    m_data[0] = '0; m_data[1] = '0;
    m_starve = 0;
    m_we = 0; m_waddr = '0; m_wdata = '0; m_busy = '0;
  endtask

  // Which pending entry wins this cycle: -1 none, 0 or 1.
  function automatic int pick();
    if (m_full[0] && m_full[1]) return (m_starve == LIMIT) ? 1 : 0;
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  task automatic model_edge(input int w);
    bit acc0, acc1;
    acc0 = wb0_valid_in && (!m_full[0] || w == 0) && (wb0_rd_in != 5'd0);
    acc1 = wb1_valid_in && (!m_full[1] || w == 1) && (wb1_rd_in != 5'd0);
    if (w >= 0) begin
      m_we = 1; m_waddr = m_rd[w]; m_wdata = m_data[w];
    end else begin
      m_we = 0;
    end
    if (w == 0 && m_full[1]) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
    else m_starve = 0;
    if (SB_ON) begin
      if (w == 1) m_busy[m_rd[1]] = 1'b0;
      if (sb_set_valid_in && sb_set_rd_in != 5'd0) m_busy[sb_set_rd_in] = 1'b1;
    end
    if (w >= 0) m_full[w] = 0;
    if (acc0) begin m_full[0] = 1; m_rd[0] = wb0_rd_in; m_data[0] = wb0_data_in; end
    if (acc1) begin m_full[1] = 1; m_rd[1] = wb1_rd_in; m_data[1] = wb1_data_in; end
  endtask

  // One clock: check ready before the edge, outputs after it; returns at the next negedge.
  task automatic step();
    int w;
    #1;
    w = pick();
    chk("ready0", 32'(wb0_ready_out), 32'(!m_full[0] || w == 0));
    chk("ready1", 32'(wb1_ready_out), 32'(!m_full[1] || w == 1));
    @(posedge aclk);
    model_edge(w);
    #1;
    chk("we", 32'(rf_we_out), 32'(m_we));
    chk("waddr", 32'(rf_waddr_out), 32'(m_waddr));
    chk("wdata", rf_wdata_out, m_wdata);
    chk("busy", busy_out, m_busy);
    @(negedge aclk);
  endtask

  task automatic idle_inputs();
    wb0_valid_in = 0; wb0_rd_in = '0; wb0_data_in = '0;
    wb1_valid_in = 0; wb1_rd_in = '0; wb1_data_in = '0;
    sb_set_valid_in = 0; sb_set_rd_in = '0;
  endtask

  initial begin
    areset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge aclk);
    chk("rst_we", 32'(rf_we_out), 32'd0);
    chk("rst_waddr", 32'(rf_waddr_out), 32'd0);
    chk("rst_wdata", rf_wdata_out, 32'd0);
    chk("rst_busy", busy_out, 32'd0);
    areset = 1'b0;
    #1;
    chk("rel_ready0", 32'(wb0_ready_out), 32'd1);
    chk("rel_ready1", 32'(wb1_ready_out), 32'd1);

    // Single wb0 write: handshake edge, then grant edge, then exactly one pulse.
    wb0_valid_in = 1; wb0_rd_in = 5'd5; wb0_data_in = 32'hDEADBEEF;
    step();
    chk("single_we_hs", 32'(rf_we_out), 32'd0);
    idle_inputs();
    step();
    chk("single_we", 32'(rf_we_out), 32'd1);
    chk("single_addr", 32'(rf_waddr_out), 32'd5);
    chk("single_data", rf_wdata_out, 32'hDEADBEEF);
    step();
    chk("single_pulse", 32'(rf_we_out), 32'd0);

    // Writes to x0 are swallowed.
    wb0_valid_in = 1; wb0_rd_in = 5'd0; wb0_data_in = 32'h1234;
    step();
    idle_inputs();
    chk("x0_ready", 32'(wb0_ready_out), 32'd1);
    step();
    chk("x0_we", 32'(rf_we_out), 32'd0);

    // Both requesters saturated: wb1 gets every fifth slot.
    for (int i = 0; i < 12; i++) begin
      wb0_valid_in = 1; wb0_rd_in = 5'd1; wb0_data_in = $urandom;
      wb1_valid_in = 1; wb1_rd_in = 5'd2; wb1_data_in = $urandom;
      step();
      chk("pat_we", 32'(rf_we_out), 32'(i > 0));
      if (i > 0) chk("pat_addr", 32'(rf_waddr_out), ((i - 1) % 5 == 4) ? 32'd2 : 32'd1);
    end
    idle_inputs();
    repeat (3) step();

    // Scoreboard: set, clear on wb1 grant, and set winning over a same-edge clear.
    sb_set_valid_in = 1; sb_set_rd_in = 5'd7;
    step();
    idle_inputs();
    chk("sb_set7", 32'(busy_out[7]), 32'(SB_ON));
    wb1_valid_in = 1; wb1_rd_in = 5'd7; wb1_data_in = 32'hA5A5_0007;
    step();
    idle_inputs();
    chk("sb_pending7", 32'(busy_out[7]), 32'(SB_ON));
    step();
    chk("sb_clear7", 32'(busy_out[7]), 32'd0);
    chk("sb_clear_addr", 32'(rf_waddr_out), 32'd7);
    sb_set_valid_in = 1; sb_set_rd_in = 5'd7;
    step();
    idle_inputs();
    wb1_valid_in = 1; wb1_rd_in = 5'd7; wb1_data_in = 32'h0BAD_0007;
    step();
    idle_inputs();
    sb_set_valid_in = 1; sb_set_rd_in = 5'd7;
    step();
    idle_inputs();
    chk("sb_set_wins", 32'(busy_out[7]), 32'(SB_ON));
    sb_set_valid_in = 1; sb_set_rd_in = 5'd3;
    step();
    idle_inputs();
    chk("sb_set3", 32'(busy_out[3]), 32'(SB_ON));

    // Asynchronous reset with both buffers full.
    wb0_valid_in = 1; wb0_rd_in = 5'd9;  wb0_data_in = 32'h1111_0009;
    wb1_valid_in = 1; wb1_rd_in = 5'd10; wb1_data_in = 32'h2222_000A;
    step();
    idle_inputs();
    #2;
    areset = 1'b1;
    model_reset();
    #1;
    chk("arst_we", 32'(rf_we_out), 32'd0);
    chk("arst_busy", busy_out, 32'd0);
    chk("arst_ready0", 32'(wb0_ready_out), 32'd1);
    chk("arst_ready1", 32'(wb1_ready_out), 32'd1);
    @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    step();
    chk("arst_no_write", 32'(rf_we_out), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      wb0_valid_in = ($urandom_range(0, 3) != 0);
      wb0_rd_in = 5'($urandom_range(0, 31));
      wb0_data_in = $urandom;
      wb1_valid_in = ($urandom_range(0, 2) == 0);
      wb1_rd_in = 5'($urandom_range(0, 31));
      wb1_data_in = $urandom;
      sb_set_valid_in = ($urandom_range(0, 3) == 0);
      sb_set_rd_in = 5'($urandom_range(0, 31));
      step();
    end
    idle_inputs();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
